// File: rtl/alu_74382_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_74382_seq
// Purpose  : Slice-serial sequencer for a single external alu_74382 instance.
//            It accepts one wide operation (ALU_W*SLICES bits) and feeds the
//            ALU one ALU_W-bit slice per cycle, LSB slice first. The ALU
//            carry_out is registered and fed back as the next slice's
//            carry_in. The assembled result is returned over valid/ready.
//
// Ports    : clk, rst            - clock; asynchronous active-high reset
//            in_valid/in_ready   - request handshake
//            in_sel, in_carry    - 74382 function select, slice-0 carry_in
//            in_a, in_b          - wide operands (ALU_W*SLICES bits)
//            alu_sel, alu_carry_in, alu_port_a, alu_port_b
//                                - drive into the ALU
//            alu_result, alu_overflow, alu_carry_out
//                                - returned from the ALU
//            out_valid/out_ready - result handshake
//            out_result          - assembled wide result
//            out_carry           - carry_out of the last slice
//            out_overflow        - overflow of the last slice
//            out_zero            - all-zero result flag (only when the
//                                  ALU_SEQ_ZERO_FLAG_EN macro is defined)
//
// Options  : `define ALU_SEQ_ZERO_FLAG_EN to build the out_zero port.
//
// Revision : 1.0 - initial release
// ============================================================================
module alu_74382_seq #(
    parameter int ALU_W  = 4,
    parameter int SLICES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_sel,
    input  logic                      in_carry,
    input  logic [ALU_W*SLICES-1:0]   in_a,
    input  logic [ALU_W*SLICES-1:0]   in_b,
    output logic [2:0]                alu_sel,
    output logic                      alu_carry_in,
    output logic [ALU_W-1:0]          alu_port_a,
    output logic [ALU_W-1:0]          alu_port_b,
    input  logic [ALU_W-1:0]          alu_result,
    input  logic                      alu_overflow,
    input  logic                      alu_carry_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALU_W*SLICES-1:0]   out_result,
    output logic                      out_carry,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic                      out_zero,
`endif
    output logic                      out_overflow
);

    localparam int c_DW    = ALU_W * SLICES;
    localparam int c_CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_sel;
    logic [c_DW-1:0]    r_a;
    logic [c_DW-1:0]    r_b;
    logic               r_carry;
    logic [c_DW-1:0]    r_result;
    logic [c_DW-1:0]    w_result_next;
    logic               r_out_carry;
    logic               r_out_ovf;
    logic               w_last;

    assign w_last = (r_cnt == c_CNT_W'(SLICES - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid)  w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_last)    w_state_next = c_ST_DONE;
            c_ST_DONE: if (out_ready) w_state_next = c_ST_IDLE;
            default:                  w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slice select: route slice[cnt] of the operands to the ALU and merge
    // the ALU result into slice[cnt] of the result being assembled.
    // ------------------------------------------------------------------
    always_comb begin
        alu_port_a    = '0;
        alu_port_b    = '0;
        w_result_next = r_result;
        for (int i = 0; i < SLICES; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                alu_port_a = r_a[i*ALU_W +: ALU_W];
                alu_port_b = r_b[i*ALU_W +: ALU_W];
                w_result_next[i*ALU_W +: ALU_W] = alu_result;
            end
        end
    end

    assign alu_sel      = r_sel;
    assign alu_carry_in = r_carry;
    assign in_ready     = (r_state == c_ST_IDLE);
    assign out_valid    = (r_state == c_ST_DONE);
    assign out_result   = r_result;
    assign out_carry    = r_out_carry;
    assign out_overflow = r_out_ovf;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_out_carry <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_sel   <= in_sel;
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_carry;
                        r_cnt   <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= alu_carry_out;
                    if (w_last) begin
                        // Counter parks at 0 so the idle ALU drive is slice 0.
                        r_cnt       <= '0;
                        r_out_carry <= alu_carry_out;
                        r_out_ovf   <= alu_overflow;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic r_zero;

    // Evaluated on the merged result so the final slice is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if ((r_state == c_ST_RUN) && w_last) begin
            r_zero <= ~|w_result_next;
        end
    end

    assign out_zero = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_74382_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_74382_seq
// Purpose  : Self-checking bench for alu_74382_seq. Contains a behavioural
//            4-bit 74382 slice driven by the sequencer, a wide-word reference
//            model, a directed vector table and randomized operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_74382_seq;

    localparam int ALU_W  = 4;
    localparam int SLICES = 4;
    localparam int DW     = ALU_W * SLICES;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_sel;
    logic            in_carry;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic [2:0]      alu_sel;
    logic            alu_carry_in;
    logic [ALU_W-1:0] alu_port_a;
    logic [ALU_W-1:0] alu_port_b;
    logic [ALU_W-1:0] alu_result;
    logic            alu_overflow;
    logic            alu_carry_out;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_result;
    logic            out_carry;
    logic            out_overflow;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic            out_zero;
`endif

    int n_tests;
    int n_fail;

    alu_74382_seq #(.ALU_W(ALU_W), .SLICES(SLICES)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_carry     (in_carry),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_sel      (alu_sel),
        .alu_carry_in (alu_carry_in),
        .alu_port_a   (alu_port_a),
        .alu_port_b   (alu_port_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_carry_out(alu_carry_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .out_zero     (out_zero),
`endif
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 74382 slice sitting on the sequencer's ALU ports.
    logic [ALU_W:0] m_t;
    always_comb begin
        m_t           = '0;
        alu_result    = '0;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_sel)
            3'b001: begin
                m_t = {1'b0, alu_port_b} + {1'b0, ~alu_port_a} + {{ALU_W{1'b0}}, alu_carry_in};
                alu_result    = m_t[ALU_W-1:0];
                alu_carry_out = m_t[ALU_W];
                alu_overflow  = (alu_port_a[ALU_W-1] != alu_port_b[ALU_W-1]) &&
                                (m_t[ALU_W-1] != alu_port_b[ALU_W-1]);
            end
            3'b010: begin
                m_t = {1'b0, alu_port_a} + {1'b0, ~alu_port_b} + {{ALU_W{1'b0}}, alu_carry_in};
                alu_result    = m_t[ALU_W-1:0];
                alu_carry_out = m_t[ALU_W];
                alu_overflow  = (alu_port_a[ALU_W-1] != alu_port_b[ALU_W-1]) &&
                                (m_t[ALU_W-1] != alu_port_a[ALU_W-1]);
            end
            3'b011: begin
                m_t = {1'b0, alu_port_a} + {1'b0, alu_port_b} + {{ALU_W{1'b0}}, alu_carry_in};
                alu_result    = m_t[ALU_W-1:0];
                alu_carry_out = m_t[ALU_W];
                alu_overflow  = (alu_port_a[ALU_W-1] == alu_port_b[ALU_W-1]) &&
                                (m_t[ALU_W-1] != alu_port_a[ALU_W-1]);
            end
            3'b100:  alu_result = alu_port_a ^ alu_port_b;
            3'b101:  alu_result = alu_port_a | alu_port_b;
            3'b110:  alu_result = alu_port_a & alu_port_b;
            3'b111:  alu_result = '1;
            default: alu_result = '0;
        endcase
    end

    // Wide-word reference: the whole operation as one arithmetic expression.
    function automatic void ref_op(input logic [2:0] s, input logic c,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   output logic [DW-1:0] r, output logic co,
                                   output logic v);
        logic [DW:0] t;
        t  = '0;
        r  = '0;
        co = 1'b0;
        v  = 1'b0;
        case (s)
            3'b000: r = '0;
            3'b001: begin
                t = {1'b0, b} + {1'b0, ~a} + (DW+1)'(c);
                r = t[DW-1:0]; co = t[DW];
                v = (a[DW-1] != b[DW-1]) && (r[DW-1] != b[DW-1]);
            end
            3'b010: begin
                t = {1'b0, a} + {1'b0, ~b} + (DW+1)'(c);
                r = t[DW-1:0]; co = t[DW];
                v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            3'b011: begin
                t = {1'b0, a} + {1'b0, b} + (DW+1)'(c);
                r = t[DW-1:0]; co = t[DW];
                v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            3'b100: r = a ^ b;
            3'b101: r = a | b;
            3'b110: r = a & b;
            default: r = '1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Issues one operation from a negedge, waits for the result, optionally
    // stalls out_ready for 'hold' cycles, then completes the handshake.
    task automatic do_op(input logic [2:0] s, input logic c,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int hold, input logic [DW-1:0] exp_r,
                         output logic [DW-1:0] r, output logic co,
                         output logic v, output logic z,
                         output int lat, output logic [3:0] cseq);
        int n;
        in_sel   = s;
        in_carry = c;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 0;
        cseq = '0;
        while (!out_valid && lat < 50) begin
            if (lat < 4) cseq[lat] = alu_carry_in;
            lat++;
            @(negedge clk);
        end
        r  = out_result;
        co = out_carry;
        v  = out_overflow;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        z  = out_zero;
`else
        z  = 1'b0;
`endif
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(out_result), 32'(exp_r));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [2:0]    sel;
        logic          cin;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic          co;
        logic          v;
        logic          z;
        int            hold;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [DW-1:0] r, er;
        logic          co, v, z, eco, ev;
        int            lat;
        logic [3:0]    cseq;
        logic [2:0]    s;
        logic          c;
        logic [DW-1:0] a, b;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{3'b011, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{3'b011, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{3'b010, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{3'b110, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 5};
        vecs[4] = '{3'b000, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{3'b111, 1'b0, 16'h1234, 16'h5678, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0};
        vecs[6] = '{3'b001, 1'b1, 16'h0003, 16'h0005, 16'h0002, 1'b1, 1'b0, 1'b0, 0};
        vecs[7] = '{3'b100, 1'b0, 16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b0, 1'b0, 0};
        vecs[8] = '{3'b101, 1'b0, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 0};
        vecs[9] = '{3'b010, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_carry  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready",   32'(in_ready),     32'd1);
        chk("rst_out_valid",  32'(out_valid),    32'd0);
        chk("rst_out_result", 32'(out_result),   32'd0);
        chk("rst_out_carry",  32'(out_carry),    32'd0);
        chk("rst_out_ovf",    32'(out_overflow), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("rst_out_zero",   32'(out_zero),     32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed table, applied back to back.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sel, vecs[i].cin, vecs[i].a, vecs[i].b, vecs[i].hold,
                  vecs[i].res, r, co, v, z, lat, cseq);
            chk("dir_result",  32'(r),   32'(vecs[i].res));
            chk("dir_carry",   32'(co),  32'(vecs[i].co));
            chk("dir_ovf",     32'(v),   32'(vecs[i].v));
            chk("dir_latency", 32'(lat), 32'(SLICES));
`ifdef ALU_SEQ_ZERO_FLAG_EN
            chk("dir_zero",    32'(z),   32'(vecs[i].z));
`endif
            if (i == 0) chk("carry_in_seq", 32'(cseq), 32'b0110);
        end

        // Reset asserted during the second RUN cycle.
        in_sel = 3'b011; in_carry = 1'b1; in_a = 16'h0FFF; in_b = 16'h0F01;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid",  32'(out_valid),  32'd0);
        chk("abort_in_ready",   32'(in_ready),   32'd1);
        chk("abort_out_result", 32'(out_result), 32'd0);
        chk("abort_out_carry",  32'(out_carry),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(3'b011, 1'b0, 16'h0001, 16'h0001, 0, 16'h0002, r, co, v, z, lat, cseq);
        chk("post_abort_result",  32'(r),   32'h0002);
        chk("post_abort_carry",   32'(co),  32'd0);
        chk("post_abort_ovf",     32'(v),   32'd0);
        chk("post_abort_latency", 32'(lat), 32'(SLICES));

        // Randomized operations against the wide-word reference.
        for (int i = 0; i < 40; i++) begin
            s = 3'($urandom_range(0, 7));
            c = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            ref_op(s, c, a, b, er, eco, ev);
            do_op(s, c, a, b, 0, er, r, co, v, z, lat, cseq);
            chk("rnd_result",  32'(r),   32'(er));
            chk("rnd_carry",   32'(co),  32'(eco));
            chk("rnd_ovf",     32'(v),   32'(ev));
            chk("rnd_latency", 32'(lat), 32'(SLICES));
`ifdef ALU_SEQ_ZERO_FLAG_EN
            chk("rnd_zero",    32'(z),   32'(er == '0));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_74382_seq.md
Name: alu_74382_seq

Overview:
- Slice-serial sequencer placed upstream of a single alu_74382 instance; it feeds that instance and consumes its outputs.
- Accepts a wide operation of ALU_W*SLICES bits and drives one ALU_W-bit slice per cycle into the ALU, LSB slice first.
- Ripples the ALU carry_out through an internal register into the next slice's carry_in.
- Assembles the full result and returns it over a valid/ready handshake.
- This is the time-multiplexed, single-ALU alternative to alu_chain.

Parameters:
ALU_W, 4, width of one ALU slice (matches the alu_74382 operand width)
SLICES, 4, number of slices per operation; total width DW = ALU_W*SLICES; must be >= 1

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
in_sel  input  3  74382 function select, same encoding as the ALU sel
in_carry  input  1  carry_in applied to slice 0
in_a  input  DW  operand A
in_b  input  DW  operand B
alu_sel  output  3  to ALU sel
alu_carry_in  output  1  to ALU carry_in
alu_port_a  output  ALU_W  to ALU port_a
alu_port_b  output  ALU_W  to ALU port_b
alu_result  input  ALU_W  from ALU result
alu_overflow  input  1  from ALU overflow
alu_carry_out  input  1  from ALU carry_out
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_result  output  DW  assembled result
out_carry  output  1  carry_out of the last slice
out_overflow  output  1  overflow of the last slice

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: in_ready=1; out_valid=0; out_result=0; out_carry=0; out_overflow=0; slice counter=0; carry register=0; operand and sel registers=0.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready is sampled, register in_sel, in_a, in_b and in_carry (into the carry register), clear the counter, and go to RUN.
- RUN:
  - in_ready=0.
  - ALU drive is combinational from registers: alu_sel = registered sel; alu_port_a/b = slice[cnt] of the registered operands; alu_carry_in = carry register.
  - Each RUN edge: write alu_result into result slice[cnt], load the carry register with alu_carry_out, increment cnt.
  - On the edge with cnt==SLICES-1, also capture alu_overflow and alu_carry_out into out_overflow/out_carry, then go to DONE.
  - RUN always lasts exactly SLICES cycles, for every sel value including clear/preset/logic ops.
- DONE:
  - out_valid=1; outputs held stable.
  - On out_valid&&out_ready, go to IDLE with out_valid=0 on the next cycle.
  - No new request is accepted in DONE.
- Latency: out_valid rises SLICES cycles after the acceptance edge. Throughput: one op per SLICES+2 cycles with out_ready held at 1.
- Outside RUN, ALU drive outputs are still driven from the registers (cnt=0); their values are don't-care.
- Carry and overflow semantics are the ALU's own: the block only chains them and never inverts.
  - Subtraction no-borrow is signalled by carry=1, which the caller supplies on in_carry.
- Intermediate slice overflow values are ignored.
- Async reset in any state aborts the operation immediately and returns all outputs to reset values; a partial result is never presented.
- SLICES=1: RUN lasts one cycle.

Optional Feature:
- Macro ALU_SEQ_ZERO_FLAG_EN.
- Defined: adds output port out_zero (1 bit) = 1 when the assembled result is all zeros.
  - Registered alongside the result on the final RUN edge; reset value 0; valid only while out_valid=1.
- Undefined: port out_zero does not exist and no zero-detect logic is built.

Test Plan:
- ALU_W=4, SLICES=4, sel=011 (A plus B), a=0x00FF, b=0x0001, cin=0 -> out_result=0x0100, out_carry=0, out_overflow=0; out_valid exactly 4 cycles after acceptance; alu_carry_in sequence 0,1,1,0.
- sel=011, a=0x7FFF, b=0x0001, cin=0 -> out_result=0x8000, out_overflow=1, out_carry=0.
- sel=010 (A minus B), a=0x0000, b=0x0001, cin=1 -> out_result=0xFFFF, out_carry=0 (borrow); with ALU_SEQ_ZERO_FLAG_EN, out_zero=0.
- sel=110 (AND), a=0xF0F0, b=0xFF00 -> out_result=0xF000. Hold out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0 throughout; then out_ready=1 -> IDLE next cycle.
- Assert rst during the 2nd RUN cycle -> out_valid=0, in_ready=1 immediately. A following add 0x0001+0x0001 gives 0x0002 with no residue from the aborted op.
- sel=000 (clear), then sel=111 (preset), back-to-back -> out_result 0x0000 then 0xFFFF; with ALU_SEQ_ZERO_FLAG_EN, out_zero 1 then 0; each op spans SLICES RUN cycles.
